// File: rtl/spi_pkg.sv
// Shared SPI constants: frame/clock-divider defaults and mode-0 polarity/phase.
// Also pulled in by the SPI master top-level wiring.
package spi_pkg;
  localparam int DATA_W_DEF            = 8;
  localparam int CLKS_PER_HALF_BIT_DEF = 2;
  localparam bit CPOL                  = 1'b0;
  localparam bit CPHA                  = 1'b0;
endpackage

// File: rtl/spi_clk_div.sv
// SCLK divider: half-period counter, sclk toggle and rise/fall strobes.
// The strobes are combinational: they flag the clk edge on which sclk changes.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = CLKS_PER_HALF_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);
  localparam int HALF_W = $clog2(CLKS_PER_HALF_BIT) + 1;

  logic [HALF_W-1:0] half_cnt;

  assign tick = run && (half_cnt == HALF_W'(CLKS_PER_HALF_BIT - 1));
  assign rise = tick && (sclk == 1'b0);
  assign fall = tick && (sclk == 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      sclk     <= CPOL;
    end else if (clear) begin
      half_cnt <= '0;
      sclk     <= CPOL;
    end else if (run) begin
      if (tick) begin
        half_cnt <= '0;
        sclk     <= ~sclk;
      end else begin
        half_cnt <= half_cnt + HALF_W'(1);
      end
    end
  end
endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift datapath driven by an external master FSM.
// Shifts MOSI out MSB first on falling SCLK, samples MISO on rising SCLK.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int CLKS_PER_HALF_BIT = CLKS_PER_HALF_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              en_d,
  input  logic              clear_d,
  input  logic              en_oclk,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              last_edge,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_dv
);
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

  logic              run, load, load_q;
  logic              tick, rise, fall;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift;

  assign run  = en_d && en_oclk && !clear_d;
  assign load = clear_d && !en_d && tx;

  spi_clk_div #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clear(clear_d),
    .run  (run),
    .sclk (sclk),
    .tick (tick),
    .rise (rise),
    .fall (fall)
  );

  // Final falling edge of the frame: 2*DATA_W-1 toggles already done.
  assign last_edge = !rst && tick && (edge_cnt == EDGE_W'(2 * DATA_W - 1));

  // mosi is valid in the cycle after load so the slave sees the MSB early.
  assign mosi = !rst && (en_d || load_q) && tx_shift[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      edge_cnt <= '0;
      rx_dv    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      rx_dv  <= last_edge;
      load_q <= load;
      if (clear_d) begin
        edge_cnt <= '0;
        if (load) begin
          tx_shift <= tx_data;
          rx_shift <= '0;
        end
      end else if (run) begin
        if (tick) edge_cnt <= edge_cnt + EDGE_W'(1);
        if (rise) rx_shift <= {rx_shift[DATA_W-2:0], miso};
        if (fall) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (last_edge) rx_data <= rx_shift;
    end
  end
endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: acts as the master FSM, checks frames against
// a byte-level model (rx byte, mosi bits, pulse counts, load-to-rx_dv latency).
module tb_spi_shift_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx = 1'b0, clear_d = 1'b1, en_d = 1'b0, en_oclk = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic sclk0, mosi0, le0, dv0, miso0;
  logic [7:0] rx0;
  logic sclk1, mosi1, le1, dv1;
  logic [7:0] rx1;

  logic       sel = 1'b0;
  logic       loop_mode = 1'b1;
  logic [7:0] mpat = 8'h00;
  int         rises = 0;
  logic [2:0] idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // miso source: loopback, or a pattern byte presented MSB first per SCLK rise
  assign idx   = (rises > 7) ? 3'd0 : 3'(7 - rises);
  assign miso0 = loop_mode ? mosi0 : mpat[idx];

  spi_shift_engine #(.DATA_W(8), .CLKS_PER_HALF_BIT(2)) dut (
    .clk(clk), .rst(rst), .tx(tx), .tx_data(tx_data), .en_d(en_d),
    .clear_d(clear_d), .en_oclk(en_oclk), .miso(miso0), .sclk(sclk0),
    .mosi(mosi0), .last_edge(le0), .rx_data(rx0), .rx_dv(dv0)
  );

  spi_shift_engine #(.DATA_W(8), .CLKS_PER_HALF_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx(tx), .tx_data(tx_data), .en_d(en_d),
    .clear_d(clear_d), .en_oclk(en_oclk), .miso(mosi1), .sclk(sclk1),
    .mosi(mosi1), .last_edge(le1), .rx_data(rx1), .rx_dv(dv1)
  );

  logic       o_sclk, o_mosi, o_le, o_dv;
  logic [7:0] o_rx;
  assign o_sclk = sel ? sclk1 : sclk0;
  assign o_mosi = sel ? mosi1 : mosi0;
  assign o_le   = sel ? le1   : le0;
  assign o_dv   = sel ? dv1   : dv0;
  assign o_rx   = sel ? rx1   : rx0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One frame as seen by the master FSM. Returns just after the next load edge
  // (has_next) or with the engine parked in clear.
  task automatic do_frame(input logic [7:0] d, input bit skip_load, input bit has_next,
                          input logic [7:0] nd, input int gl, input int st,
                          output logic [7:0] rx, output int lat, output logic [7:0] mb,
                          output int nl, output int ndv, output int ntog);
    bit done = 0;
    bit prev = 0;
    int cyc = 0;
    rx = 8'h00; lat = -1; mb = 8'h00; nl = 0; ndv = 0; ntog = 0;
    if (!skip_load) begin
      tx = 1'b1; tx_data = d; clear_d = 1'b1; en_d = 1'b0; en_oclk = 1'b0;
      @(posedge clk); #1;
    end
    rises = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      cyc++;
      clear_d = 1'b0; en_d = 1'b1;
      tx      = (cyc == gl);
      tx_data = (cyc == gl) ? 8'hFF : d;
      en_oclk = !(st > 0 && cyc >= st && cyc < st + 3);
      @(negedge clk);
      if (o_sclk != prev) ntog++;
      if (o_sclk && !prev) begin
        rises++;
        mb = {mb[6:0], o_mosi};
      end
      prev = o_sclk;
      nl  += int'(o_le);
      ndv += int'(o_dv);
      if (o_le) begin
        @(posedge clk); #1;
        cyc++;
        en_d = 1'b0; en_oclk = 1'b0; clear_d = 1'b1;
        tx = has_next; tx_data = nd;
        @(negedge clk);
        if (o_sclk != prev) ntog++;
        nl += int'(o_le);
        if (o_dv) begin
          ndv++;
          lat = cyc;
        end
        rx = o_rx;
        @(posedge clk); #1;
        tx = 1'b0;
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: no last_edge within 300 cycles for data %0h", d);
      en_d = 1'b0; en_oclk = 1'b0; clear_d = 1'b1; tx = 1'b0;
    end
  endtask

  task automatic run_chk(input string nm, input logic [7:0] d, input bit skip_load,
                         input bit has_next, input logic [7:0] nd, input int gl,
                         input int st, input int cphb, input logic [7:0] exp_rx);
    logic [7:0] rx, mb;
    int lat, nl, ndv, ntog;
    do_frame(d, skip_load, has_next, nd, gl, st, rx, lat, mb, nl, ndv, ntog);
    chk({nm, " rx_data"}, rx, exp_rx);
    chk({nm, " latency"}, lat, 1 + 2 * 8 * cphb + ((st > 0) ? 3 : 0));
    chk({nm, " mosi_bits"}, mb, d);
    chk({nm, " sclk_toggles"}, ntog, 16);
    chk({nm, " last_edge_pulses"}, nl, 1);
    chk({nm, " rx_dv_pulses"}, ndv, 1);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         lp;
    logic [7:0] mp;
    int         gl;
    int         st;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    vec_t vt[4];
    logic [7:0] rd, rm;
    bit rl;
    int ntog, ndv;

    vt[0] = '{8'hA5, 1'b1, 8'h00, 0,  0, 8'hA5};  // loopback
    vt[1] = '{8'h00, 1'b0, 8'hFF, 0,  0, 8'hFF};  // miso held high
    vt[2] = '{8'h11, 1'b1, 8'h00, 10, 0, 8'h11};  // tx pulse mid-frame ignored
    vt[3] = '{8'h96, 1'b0, 8'h5C, 0,  9, 8'h5C};  // 3-cycle en_oclk freeze

    // reset state, before any clock edge
    #2;
    chk("rst sclk", sclk0, 1'b0);
    chk("rst mosi", mosi0, 1'b0);
    chk("rst last_edge", le0, 1'b0);
    chk("rst rx_dv", dv0, 1'b0);
    chk("rst rx_data", rx0, 8'h00);
    chk("rst rx_data c1", rx1, 8'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      loop_mode = vt[i].lp;
      mpat      = vt[i].mp;
      run_chk($sformatf("vec%0d", i), vt[i].d, 0, 0, 8'h00, vt[i].gl, vt[i].st, 2, vt[i].exp_rx);
    end

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      rm = 8'($urandom);
      rl = 1'($urandom);
      loop_mode = rl;
      mpat      = rm;
      run_chk($sformatf("rand%0d", i), rd, 0, 0, 8'h00, 0, 0, 2, rl ? rd : rm);
    end

    // back-to-back: second load coincides with the first rx_dv
    loop_mode = 1'b1;
    run_chk("b2b first", 8'h3C, 0, 1, 8'hC3, 0, 0, 2, 8'h3C);
    run_chk("b2b second", 8'hC3, 1, 0, 8'h00, 0, 0, 2, 8'hC3);

    // reset at the fifth sclk edge aborts the frame
    tx = 1'b1; tx_data = 8'h77; clear_d = 1'b1; en_d = 1'b0; en_oclk = 1'b0;
    @(posedge clk); #1;
    tx = 1'b0; clear_d = 1'b0; en_d = 1'b1; en_oclk = 1'b1;
    begin
      bit prev = 0;
      ntog = 0;
      for (int t = 0; t < 100 && ntog < 5; t++) begin
        @(negedge clk);
        if (sclk0 != prev) ntog++;
        prev = sclk0;
      end
    end
    chk("abort reached edge5", ntog, 5);
    #2 rst = 1'b1;
    #1;
    chk("abort sclk", sclk0, 1'b0);
    chk("abort mosi", mosi0, 1'b0);
    chk("abort last_edge", le0, 1'b0);
    chk("abort rx_dv", dv0, 1'b0);
    chk("abort rx_data", rx0, 8'h00);
    @(posedge clk); #1;
    en_d = 1'b0; en_oclk = 1'b0; clear_d = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndv = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      ndv += int'(dv0);
    end
    chk("abort no rx_dv", ndv, 0);
    @(posedge clk); #1;
    run_chk("after abort", 8'h5A, 0, 0, 8'h00, 0, 0, 2, 8'h5A);

    // one-clock half period on the second instance
    sel = 1'b1;
    run_chk("cphb1", 8'h81, 0, 0, 8'h00, 0, 0, 1, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter DATA_W, default 8: bits per SPI frame.
REQ-002 Parameter CLKS_PER_HALF_BIT, default 2, legal values >=1: clk cycles per SCLK half-period.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tx  input  1  transmit request (i_TX_DV), shared with the SPI master FSM.
REQ-006 tx_data  input  DATA_W  byte to transmit, sampled with tx.
REQ-007 en_d  input  1  from FSM: transfer in progress.
REQ-008 clear_d  input  1  from FSM: hold/clear datapath.
REQ-009 en_oclk  input  1  from FSM: SCLK generation enable.
REQ-010 miso  input  1  serial data from slave.
REQ-011 sclk  output  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 mosi  output  1  serial data to slave, MSB first.
REQ-013 last_edge  output  1  to FSM: final SCLK edge of the frame occurs at the next clk edge.
REQ-014 rx_data  output  DATA_W  last received frame, MSB first.
REQ-015 rx_dv  output  1  one-cycle strobe: rx_data updated.

Function
REQ-016 Load: when clear_d=1, en_d=0 and tx=1, the block SHALL capture tx_data into tx_shift, clear half_cnt, edge_cnt and rx_shift, and force sclk=0.
REQ-017 Clear without tx: when clear_d=1, the block SHALL hold half_cnt=0, edge_cnt=0 and sclk=0, and leave tx_shift and rx_data unchanged.
REQ-018 Run: when en_d=1, en_oclk=1 and clear_d=0, half_cnt SHALL increment each cycle; at CLKS_PER_HALF_BIT-1 it SHALL wrap to 0, toggle sclk and increment edge_cnt.
REQ-019 Freeze: en_d=1 with en_oclk=0 SHALL hold sclk and all counters and shift registers.
REQ-020 Rising SCLK edge (sclk 0->1): the block SHALL shift miso into rx_shift LSB.
REQ-021 Falling SCLK edge (sclk 1->0): the block SHALL shift tx_shift left by one, filling with 0.
REQ-022 mosi SHALL equal tx_shift[DATA_W-1] whenever en_d=1 or in the load cycle's successor; mosi SHALL be 0 otherwise.
REQ-023 last_edge SHALL be a combinational decode: en_d=1, en_oclk=1, half_cnt=CLKS_PER_HALF_BIT-1 and edge_cnt=2*DATA_W-1; it is high for exactly one cycle per frame.
REQ-024 On the clk edge ending the last_edge cycle, the block SHALL copy rx_shift into rx_data, and rx_dv SHALL be 1 in the following cycle only.
REQ-025 Latency: from the tx load cycle to the rx_dv cycle, the block SHALL take 1+2*DATA_W*CLKS_PER_HALF_BIT cycles (33 at defaults).
REQ-026 The block SHALL ignore tx while en_d=1; a frame in progress SHALL NOT be reloaded.
REQ-027 The block SHALL accept back-to-back frames: tx in the cycle after the last_edge cycle SHALL load normally, with rx_dv of the prior frame asserted concurrently.
REQ-028 With CLKS_PER_HALF_BIT=1, sclk SHALL toggle every en_d cycle, and REQ-023 SHALL still yield a single last_edge pulse.

Reset
REQ-029 While rst=1, the block SHALL force sclk=0, mosi=0, last_edge=0, rx_dv=0, rx_data=0 and all internal counters and shift registers to 0, regardless of clk.
REQ-030 A reset during a frame SHALL abort the frame with no rx_dv; after reset the block SHALL wait for a new load per REQ-016.

Structure
REQ-031 Shared package spi_pkg SHALL hold DATA_W default, CLKS_PER_HALF_BIT default and the mode-0 CPOL/CPHA constants, and SHALL be reused by fsm_SPI_master top-level wiring.
REQ-032 A single sub-module spi_clk_div SHALL contain half_cnt, the sclk toggle and the rise/fall edge strobes; shifting and edge counting SHALL stay in spi_shift_engine.
REQ-033 edge_cnt width SHALL be clog2(2*DATA_W)+1 bits, and half_cnt width SHALL be clog2(CLKS_PER_HALF_BIT)+1 bits.

Verification
REQ-034 Loopback, defaults: miso tied to mosi, tx_data=8'hA5 -> 8 sclk pulses, mosi bits 1,0,1,0,0,1,0,1, rx_data=8'hA5, rx_dv 33 cycles after load.
REQ-035 miso held 1, tx_data=8'h00 -> mosi constant 0, rx_data=8'hFF, exactly one last_edge pulse and one rx_dv pulse.
REQ-036 Back-to-back: 8'h3C then 8'hC3 with tx in the cycle after last_edge -> second frame starts without gap, rx_data 8'h3C then 8'hC3, two rx_dv pulses 33 cycles apart.
REQ-037 rst asserted at sclk edge 5 of a frame -> all outputs 0 asynchronously, no rx_dv, next frame of 8'h5A returns 8'h5A in loopback.
REQ-038 CLKS_PER_HALF_BIT=1, loopback 8'h81 -> sclk period 2 cycles, rx_dv 17 cycles after load, rx_data=8'h81.
REQ-039 tx pulsed mid-frame with tx_data=8'hFF during a 8'h11 frame -> transfer unaffected, rx_data=8'h11 in loopback.
